// File: rtl/m3_speed_pkg.sv
// Shared encodings for the motor-3 speed ramp controller: FSM states and
// the step direction used by the hysteresis logic and the step calculator.
package m3_speed_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STOP_RAMP = 3'd2,
        HALT      = 3'd3,
        REV_RAMP  = 3'd4
    } stateE;

    // Step direction: INC shortens the period (faster), DEC lengthens it
    typedef enum logic {
        MODE_INC = 1'b0,
        MODE_DEC = 1'b1
    } modeE;

endpackage

// File: rtl/m3_ramp_step.sv
// Combinational period step: moves the round period by max(len >> STEP_SHIFT, 1)
// towards PERIOD_MIN (INC) or PERIOD_MAX (DEC), clamped at the limits.
// The arithmetic is one bit wider than the period so the sum never wraps.
module m3_ramp_step
    import m3_speed_pkg::*;
#(
    parameter int W          = 32,
    parameter int PERIOD_MIN = 40,
    parameter int PERIOD_MAX = 250000,
    parameter int STEP_SHIFT = 4
)(
    input  logic [W-1:0] len,
    input  modeE         mode,
    output logic [W-1:0] nextLen
);

    localparam logic [W:0] MinExt = (W+1)'(PERIOD_MIN);
    localparam logic [W:0] MaxExt = (W+1)'(PERIOD_MAX);

    logic [W:0] lenExt;
    logic [W:0] delta;
    logic [W:0] shrunk;
    logic [W:0] grown;

    // Compute the proportional step (never zero) and clamp the result to the period limits
    always_comb begin
        lenExt  = {1'b0, len};
        delta   = lenExt >> STEP_SHIFT;
        if (delta == '0) begin
            delta = (W+1)'(1);
        end
        shrunk  = lenExt - delta;
        grown   = lenExt + delta;
        nextLen = len;
        if (mode == MODE_INC) begin
            if ((lenExt > delta) && (shrunk > MinExt)) begin
                nextLen = shrunk[W-1:0];
            end else begin
                nextLen = MinExt[W-1:0];
            end
        end else begin
            if (grown > MaxExt) begin
                nextLen = MaxExt[W-1:0];
            end else begin
                nextLen = grown[W-1:0];
            end
        end
    end

endmodule

// File: rtl/m3_speed_ramp_ctrl.sv
// Motor-3 speed ramp controller. Adjusts the commutation round period once per
// calculation strobe with round-count hysteresis, ramps down to a halt on a
// force-stop request, and ramps down before reversing the rotation direction.
module m3_speed_ramp_ctrl
    import m3_speed_pkg::*;
#(
    parameter int W          = 32,
    parameter int CNT_W      = 4,
    parameter int ROUND_MAX  = 3,
    parameter int STEP_SHIFT = 4,
    parameter int PERIOD_MIN = 40,
    parameter int PERIOD_MAX = 250000
)(
    input  logic         clkI,
    input  logic         rstI,
    input  logic         workingI,
    input  logic         nextCalc_1I,
    input  logic         speedIncI,
    input  logic         speedDecI,
    input  logic         forceStopI,
    input  logic         invRotateI,
    output logic [W-1:0] dstRoundLenO,
    output logic         dirO,
    output logic         atMinO,
    output logic         atMaxO,
    output logic         stoppedO
);

    localparam logic [CNT_W-1:0] CntReload = CNT_W'(ROUND_MAX);
    localparam logic [W-1:0]     LenMin    = W'(PERIOD_MIN);
    localparam logic [W-1:0]     LenMax    = W'(PERIOD_MAX);

    stateE            state;
    modeE             lastMode;
    modeE             stepMode;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     lenQ;
    logic [W-1:0]     nextLen;
    logic             dirQ;
    logic             stoppedQ;

    // Step direction: only a RUN speed-up request shortens the period, every ramp lengthens it
    always_comb begin
        stepMode = MODE_DEC;
        if ((state == RUN) && speedIncI) begin
            stepMode = MODE_INC;
        end
    end

    m3_ramp_step #(
        .W          (W),
        .PERIOD_MIN (PERIOD_MIN),
        .PERIOD_MAX (PERIOD_MAX),
        .STEP_SHIFT (STEP_SHIFT)
    ) uStep (
        .len     (lenQ),
        .mode    (stepMode),
        .nextLen (nextLen)
    );

    // Controller FSM with registered period, direction and stop flag
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state    <= IDLE;
            lenQ     <= LenMax;
            cnt      <= CntReload;
            lastMode <= MODE_INC;
            dirQ     <= 1'b0;
            stoppedQ <= 1'b0;
        end else if (!workingI) begin
            state    <= IDLE;
            lenQ     <= LenMax;
            cnt      <= CntReload;
            lastMode <= MODE_INC;
            dirQ     <= invRotateI;
            stoppedQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dirQ  <= invRotateI;
                    state <= RUN;
                end
                RUN: begin
                    if (nextCalc_1I) begin
                        if (forceStopI) begin
                            state <= STOP_RAMP;
                        end else if (invRotateI != dirQ) begin
                            state <= REV_RAMP;
                        end else if (speedIncI || speedDecI) begin
                            if (stepMode != lastMode) begin
                                lastMode <= stepMode;
                                cnt      <= CntReload;
                            end else if (cnt == '0) begin
                                lenQ <= nextLen;
                                cnt  <= CntReload;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end else begin
                            cnt <= CntReload;
                        end
                    end
                end
                STOP_RAMP: begin
                    if (nextCalc_1I) begin
                        if (lenQ == LenMax) begin
                            state    <= HALT;
                            stoppedQ <= 1'b1;
                        end else begin
                            lenQ <= nextLen;
                        end
                    end
                end
                HALT: begin
                    lenQ <= LenMax;
                    if (nextCalc_1I && !forceStopI) begin
                        state    <= RUN;
                        stoppedQ <= 1'b0;
                        cnt      <= CntReload;
                        lastMode <= MODE_INC;
                    end
                end
                REV_RAMP: begin
                    if (nextCalc_1I) begin
                        if (forceStopI) begin
                            state <= STOP_RAMP;
                        end else if (invRotateI == dirQ) begin
                            state <= RUN;
                        end else if (lenQ == LenMax) begin
                            dirQ     <= invRotateI;
                            cnt      <= CntReload;
                            lastMode <= MODE_INC;
                            state    <= RUN;
                        end else begin
                            lenQ <= nextLen;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dstRoundLenO = lenQ;
    assign dirO         = dirQ;
    assign stoppedO     = stoppedQ;
    assign atMinO       = (lenQ == LenMin);
    assign atMaxO       = (lenQ == LenMax);

endmodule

// File: tb/tb_m3_speed_ramp_ctrl.sv
// Testbench for m3_speed_ramp_ctrl: fixed vector table, hand-written corner
// sequences and a randomized run checked against a behavioural model.
module tb_m3_speed_ramp_ctrl;

    localparam int PMin = 40;
    localparam int PMax = 1000;
    localparam int RMax = 3;

    logic        clkI = 1'b0;
    logic        rstI;
    logic        workingI;
    logic        nextCalc_1I;
    logic        speedIncI;
    logic        speedDecI;
    logic        forceStopI;
    logic        invRotateI;
    logic [31:0] dstRoundLenO;
    logic        dirO;
    logic        atMinO;
    logic        atMaxO;
    logic        stoppedO;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    string mPhase  = "idle";
    int    mLen    = PMax;
    int    mWait   = RMax;
    bit    mFaster = 1'b1;
    bit    mDir    = 1'b0;
    bit    mStop   = 1'b0;

    typedef struct {
        bit rst;
        bit working;
        bit strobe;
        bit inc;
        bit dec;
        bit stop;
        bit inv;
        int expLen;
        bit expDir;
        bit expStopped;
    } VecT;

    VecT vecs[17];

    m3_speed_ramp_ctrl #(
        .W          (32),
        .CNT_W      (4),
        .ROUND_MAX  (RMax),
        .STEP_SHIFT (4),
        .PERIOD_MIN (PMin),
        .PERIOD_MAX (PMax)
    ) dut (
        .clkI         (clkI),
        .rstI         (rstI),
        .workingI     (workingI),
        .nextCalc_1I  (nextCalc_1I),
        .speedIncI    (speedIncI),
        .speedDecI    (speedDecI),
        .forceStopI   (forceStopI),
        .invRotateI   (invRotateI),
        .dstRoundLenO (dstRoundLenO),
        .dirO         (dirO),
        .atMinO       (atMinO),
        .atMaxO       (atMaxO),
        .stoppedO     (stoppedO)
    );

    always #5 clkI = ~clkI;

    // Period after one step: 1/16 of the period (at least 1), clamped to the limits
    function automatic int stepped(input int len, input bit faster);
        int d;
        d = len / 16;
        if (d < 1) d = 1;
        if (faster) return (len - d > PMin) ? len - d : PMin;
        return (len + d > PMax) ? PMax : len + d;
    endfunction

    // Reference behaviour for one clock edge, using the inputs applied at that edge
    task automatic modelUpdate();
        if (rstI || !workingI) begin
            mPhase  = "idle";
            mLen    = PMax;
            mWait   = RMax;
            mFaster = 1'b1;
            mDir    = rstI ? 1'b0 : invRotateI;
            mStop   = 1'b0;
        end else if (mPhase == "idle") begin
            mPhase = "run";
            mDir   = invRotateI;
        end else if (nextCalc_1I) begin
            if (mPhase == "run") begin
                if (forceStopI) mPhase = "stop";
                else if (invRotateI != mDir) mPhase = "rev";
                else if (speedIncI || speedDecI) begin
                    if (speedIncI != mFaster) begin
                        mFaster = speedIncI;
                        mWait   = RMax;
                    end else if (mWait == 0) begin
                        mLen  = stepped(mLen, mFaster);
                        mWait = RMax;
                    end else begin
                        mWait--;
                    end
                end else begin
                    mWait = RMax;
                end
            end else if (mPhase == "stop") begin
                if (mLen == PMax) begin
                    mPhase = "halt";
                    mStop  = 1'b1;
                end else begin
                    mLen = stepped(mLen, 1'b0);
                end
            end else if (mPhase == "halt") begin
                if (!forceStopI) begin
                    mPhase  = "run";
                    mStop   = 1'b0;
                    mWait   = RMax;
                    mFaster = 1'b1;
                end
            end else begin
                if (forceStopI) mPhase = "stop";
                else if (invRotateI == mDir) mPhase = "run";
                else if (mLen == PMax) begin
                    mDir    = invRotateI;
                    mWait   = RMax;
                    mFaster = 1'b1;
                    mPhase  = "run";
                end else begin
                    mLen = stepped(mLen, 1'b0);
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it in, and leave outputs ready to sample
    task automatic applyStimulus(input bit rst, input bit w, input bit s, input bit inc,
                                 input bit dec, input bit stp, input bit inv);
        rstI        = rst;
        workingI    = w;
        nextCalc_1I = s;
        speedIncI   = inc;
        speedDecI   = dec;
        forceStopI  = stp;
        invRotateI  = inv;
        @(posedge clkI);
        modelUpdate();
        #1;
        nextCalc_1I = 1'b0;
        rstI        = 1'b0;
    endtask

    // Compare all outputs against the expected period, direction and stop flag
    task automatic checkOutput(input string name, input int expLen, input bit expDir,
                               input bit expStopped);
        bit expMin;
        bit expMax;
        expMin = (expLen == PMin);
        expMax = (expLen == PMax);
        checks++;
        if (dstRoundLenO !== 32'(expLen) || dirO !== expDir || stoppedO !== expStopped ||
            atMinO !== expMin || atMaxO !== expMax) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got len=%0d dir=%0b stopped=%0b atMin=%0b atMax=%0b, want len=%0d dir=%0b stopped=%0b atMin=%0b atMax=%0b",
                     name, $time, dstRoundLenO, dirO, stoppedO, atMinO, atMaxO,
                     expLen, expDir, expStopped, expMin, expMax);
        end
    endtask

    // Reset, enable, and four speed-up strobes: period lands on 938, direction 0
    task automatic runTo938();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 1, 1, 0, 0, 0);
        checkOutput("to938", 938, 0, 0);
    endtask

    initial begin
        int exp;
        int holdSeen;
        int incBias;
        bit inv;

        rstI = 1'b1; workingI = 1'b0; nextCalc_1I = 1'b0; speedIncI = 1'b0;
        speedDecI = 1'b0; forceStopI = 1'b0; invRotateI = 1'b0;

        // rst, working, strobe, inc, dec, stop, inv, len, dir, stopped
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 1000, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 1000, 0, 0};
        vecs[2]  = '{0, 1, 0, 1, 0, 0, 0, 1000, 0, 0};
        vecs[3]  = '{0, 1, 1, 1, 0, 0, 0, 1000, 0, 0};
        vecs[4]  = '{0, 1, 1, 1, 0, 0, 0, 1000, 0, 0};
        vecs[5]  = '{0, 1, 1, 1, 0, 0, 0, 1000, 0, 0};
        vecs[6]  = '{0, 1, 1, 1, 1, 0, 0,  938, 0, 0};
        vecs[7]  = '{0, 1, 1, 0, 1, 0, 0,  938, 0, 0};
        vecs[8]  = '{0, 1, 1, 0, 1, 0, 0,  938, 0, 0};
        vecs[9]  = '{0, 1, 1, 0, 1, 0, 0,  938, 0, 0};
        vecs[10] = '{0, 1, 1, 0, 1, 0, 0,  938, 0, 0};
        vecs[11] = '{0, 1, 1, 0, 1, 0, 0,  996, 0, 0};
        vecs[12] = '{0, 1, 1, 0, 1, 0, 0,  996, 0, 0};
        vecs[13] = '{0, 1, 1, 0, 1, 0, 0,  996, 0, 0};
        vecs[14] = '{0, 1, 1, 0, 1, 0, 0,  996, 0, 0};
        vecs[15] = '{0, 1, 1, 0, 1, 0, 0, 1000, 0, 0};
        vecs[16] = '{0, 1, 1, 0, 1, 0, 0, 1000, 0, 0};

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].working, vecs[i].strobe, vecs[i].inc,
                          vecs[i].dec, vecs[i].stop, vecs[i].inv);
            checkOutput($sformatf("vec%0d", i), vecs[i].expLen, vecs[i].expDir, vecs[i].expStopped);
        end

        // Speed up all the way to the minimum period and confirm it holds there
        applyStimulus(0, 1, 1, 1, 0, 0, 0);
        checkOutput("incSwitch", 1000, 0, 0);
        exp = 1000;
        holdSeen = 0;
        for (int step = 0; step < 80 && holdSeen < 2; step++) begin
            repeat (4) applyStimulus(0, 1, 1, 1, 0, 0, 0);
            if (exp == PMin) holdSeen++;
            exp = stepped(exp, 1'b1);
            checkOutput("incRamp", exp, 0, 0);
        end

        // Reverse: ramp down to the maximum period, flip, then resume with fresh hysteresis
        runTo938();
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkOutput("revEnter", 938, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkOutput("revRamp1", 996, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkOutput("revRamp2", 1000, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkOutput("revFlip", 1000, 1, 0);
        repeat (3) applyStimulus(0, 1, 1, 1, 0, 0, 1);
        checkOutput("revRunCnt", 1000, 1, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 1);
        checkOutput("revRunStep", 938, 1, 0);
        // Reverse aborted mid-ramp keeps the period where it was
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("abortEnter", 938, 1, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("abortRamp", 996, 1, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkOutput("abort", 996, 1, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkOutput("abortHeld", 996, 1, 0);

        // Force-stop pulse: latched ramp to halt, then release back to run
        runTo938();
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
        checkOutput("stopEnter", 938, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("stopRamp1", 996, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("stopRamp2", 1000, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("halt", 1000, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 1, 0);
        checkOutput("haltHeld", 1000, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("haltNoStrobe", 1000, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("haltRelease", 1000, 0, 0);
        repeat (4) applyStimulus(0, 1, 1, 1, 0, 0, 0);
        checkOutput("haltResume", 938, 0, 0);

        // workingI dropped mid stop ramp returns to idle values, direction follows invRotateI
        runTo938();
        applyStimulus(0, 1, 1, 0, 0, 1, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkOutput("dropRamp", 996, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("dropIdle", 1000, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(0, 1, 1, 1, 0, 0, 1);
        checkOutput("dropResume", 938, 1, 0);
        // Reset wins over a coincident strobe; a strobe in idle is ignored
        applyStimulus(1, 1, 1, 1, 0, 0, 1);
        checkOutput("rstStrobe", 1000, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 1, 1);
        checkOutput("idleStrobe", 1000, 1, 0);
        repeat (4) applyStimulus(0, 1, 1, 1, 0, 0, 1);
        checkOutput("rstResume", 938, 1, 0);

        // Randomized run against the behavioural model
        inv = invRotateI;
        incBias = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) incBias = $urandom_range(0, 4);
            if ($urandom_range(0, 59) == 0) inv = ~inv;
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 149) != 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) < incBias,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 39) == 0,
                          inv);
            checkOutput("rand", mLen, mDir, mStop);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
